// File: rtl/coproc_matmul_param.sv
// DIM x DIM signed matrix-multiply coprocessor on the custom0 genfifo streams: LOAD -> COMPUTE -> DRAIN.
// Optional build macro COPROC_MATMUL_SAT_EN: saturating arithmetic plus a sticky sat_o flag.
module coproc_matmul_param #(
  parameter int DIM    = 8,
  parameter int DATA_W = 32,
  parameter int RES_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stream_req_bus_genfifo_req_i,
  input  logic [DATA_W-1:0] stream_req_bus_genfifo_src0_data_bi,
  input  logic [DATA_W-1:0] stream_req_bus_genfifo_src1_data_bi,
  output logic              stream_req_bus_genfifo_ack_o,
  output logic              stream_resp_bus_genfifo_req_o,
  output logic [RES_W-1:0]  stream_resp_bus_genfifo_wdata_bo,
  input  logic              stream_resp_bus_genfifo_ack_i,
`ifdef COPROC_MATMUL_SAT_EN
  output logic              sat_o,
`endif
  output logic              busy_o
);

  localparam int IW = $clog2(DIM);
  localparam logic [IW-1:0] LAST = IW'(DIM - 1);

  typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_DRAIN} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] row_q, row_d, col_q, col_d;
  logic          adv, last, req_xfer, resp_xfer;

  logic signed [DATA_W-1:0] a_q   [DIM][DIM];
  logic signed [DATA_W-1:0] b_q   [DIM][DIM];
  logic signed [RES_W-1:0]  c_q   [DIM][DIM];
  logic signed [RES_W-1:0]  acc_q [DIM];
  logic signed [RES_W-1:0]  acc_d [DIM];

  assign stream_req_bus_genfifo_ack_o     = stream_req_bus_genfifo_req_i & (state_q == S_LOAD) & ~rst_i;
  assign stream_resp_bus_genfifo_req_o    = (state_q == S_DRAIN);
  assign stream_resp_bus_genfifo_wdata_bo = (state_q == S_DRAIN) ? c_q[row_q][col_q] : '0;
  assign busy_o    = (state_q != S_LOAD);
  assign req_xfer  = stream_req_bus_genfifo_req_i & stream_req_bus_genfifo_ack_o;
  assign resp_xfer = stream_resp_bus_genfifo_req_o & stream_resp_bus_genfifo_ack_i;
  assign last      = (row_q == LAST) && (col_q == LAST);

  // One row/col counter pair serves as load index n, compute (i,k) and drain index m.
  always_comb begin
    state_d = state_q;
    adv     = 1'b0;
    row_d   = row_q;
    col_d   = col_q;
    unique case (state_q)
      S_LOAD: begin
        adv = req_xfer;
        if (req_xfer && last) state_d = S_COMPUTE;
      end
      S_COMPUTE: begin
        adv = 1'b1;
        if (last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        adv = resp_xfer;
        if (resp_xfer && last) state_d = S_LOAD;
      end
      default: state_d = S_LOAD;
    endcase
    if (adv) begin
      if (col_q == LAST) begin
        col_d = '0;
        row_d = (row_q == LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

`ifdef COPROC_MATMUL_SAT_EN
  localparam int PW = (2 * DATA_W > RES_W) ? 2 * DATA_W : RES_W;
  localparam logic signed [PW-1:0]    PMAX = {{(PW - RES_W + 1){1'b0}}, {(RES_W - 1){1'b1}}};
  localparam logic signed [PW-1:0]    PMIN = ~PMAX;
  localparam logic signed [RES_W-1:0] RMAX = {1'b0, {(RES_W - 1){1'b1}}};
  localparam logic signed [RES_W-1:0] RMIN = ~RMAX;

  logic clip_any, sat_q;
  assign sat_o = sat_q;

  always_comb begin
    clip_any = 1'b0;
    for (int unsigned j = 0; j < DIM; j++) begin
      logic signed [RES_W-1:0] base, pt;
      logic signed [PW-1:0]    pa, pb, prod;
      logic        [RES_W:0]   sum;
      base = (col_q == '0) ? '0 : acc_q[j];
      pa   = a_q[row_q][col_q];
      pb   = b_q[col_q][j];
      prod = pa * pb;
      if (prod > PMAX) begin
        pt = RMAX;
        clip_any = 1'b1;
      end else if (prod < PMIN) begin
        pt = RMIN;
        clip_any = 1'b1;
      end else begin
        pt = prod[RES_W-1:0];
      end
      // Sign-extended RES_W+1 sum: top two bits differ exactly on overflow.
      sum = {base[RES_W-1], base} + {pt[RES_W-1], pt};
      if (sum[RES_W] != sum[RES_W-1]) begin
        acc_d[j] = sum[RES_W] ? RMIN : RMAX;
        clip_any = 1'b1;
      end else begin
        acc_d[j] = sum[RES_W-1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sat_q <= 1'b0;
    end else if (state_q == S_LOAD && state_d == S_COMPUTE) begin
      sat_q <= 1'b0;
    end else if (state_q == S_COMPUTE && clip_any) begin
      sat_q <= 1'b1;
    end
  end
`else
  always_comb begin
    for (int unsigned j = 0; j < DIM; j++) begin
      logic signed [RES_W-1:0] base, pa, pb, prod;
      base     = (col_q == '0) ? '0 : acc_q[j];
      pa       = a_q[row_q][col_q];
      pb       = b_q[col_q][j];
      prod     = pa * pb;
      acc_d[j] = base + prod;
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_LOAD;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (req_xfer) begin
      a_q[row_q][col_q] <= stream_req_bus_genfifo_src0_data_bi;
      b_q[row_q][col_q] <= stream_req_bus_genfifo_src1_data_bi;
    end
    if (state_q == S_COMPUTE) begin
      for (int unsigned j = 0; j < DIM; j++) begin
        acc_q[j] <= acc_d[j];
        if (col_q == LAST) c_q[row_q][j] <= acc_d[j];
      end
    end
  end

endmodule

// File: tb/tb_coproc_matmul_param.sv
// Directed scoreboard bench for coproc_matmul_param: a DIM=2 and a default DIM=8 instance.
module tb_coproc_matmul_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req2, ack2, rreq2, rack2, busy2;
  logic [31:0] s0_2, s1_2, wd2;
  logic        req8, ack8, rreq8, rack8, busy8;
  logic [31:0] s0_8, s1_8, wd8;
`ifdef COPROC_MATMUL_SAT_EN
  logic        sat2, sat8;
`endif

  coproc_matmul_param #(.DIM(2), .DATA_W(32), .RES_W(32)) u2 (
    .clk_i(clk), .rst_i(rst),
    .stream_req_bus_genfifo_req_i(req2),
    .stream_req_bus_genfifo_src0_data_bi(s0_2),
    .stream_req_bus_genfifo_src1_data_bi(s1_2),
    .stream_req_bus_genfifo_ack_o(ack2),
    .stream_resp_bus_genfifo_req_o(rreq2),
    .stream_resp_bus_genfifo_wdata_bo(wd2),
    .stream_resp_bus_genfifo_ack_i(rack2),
`ifdef COPROC_MATMUL_SAT_EN
    .sat_o(sat2),
`endif
    .busy_o(busy2)
  );

  coproc_matmul_param u8 (
    .clk_i(clk), .rst_i(rst),
    .stream_req_bus_genfifo_req_i(req8),
    .stream_req_bus_genfifo_src0_data_bi(s0_8),
    .stream_req_bus_genfifo_src1_data_bi(s1_8),
    .stream_req_bus_genfifo_ack_o(ack8),
    .stream_resp_bus_genfifo_req_o(rreq8),
    .stream_resp_bus_genfifo_wdata_bo(wd8),
    .stream_resp_bus_genfifo_ack_i(rack8),
`ifdef COPROC_MATMUL_SAT_EN
    .sat_o(sat8),
`endif
    .busy_o(busy8)
  );

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  int          ma[256];
  int          mb[256];
  logic        exp_sat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic g_ack(input bit s);  return s ? ack8  : ack2;  endfunction
  function automatic logic g_rreq(input bit s); return s ? rreq8 : rreq2; endfunction
  function automatic logic g_busy(input bit s); return s ? busy8 : busy2; endfunction
  function automatic logic [31:0] g_wd(input bit s); return s ? wd8 : wd2; endfunction

  task automatic drive_req(input bit s, input logic r, input logic [31:0] d0, input logic [31:0] d1);
    if (s) begin req8 = r; s0_8 = d0; s1_8 = d1; end
    else   begin req2 = r; s0_2 = d0; s1_2 = d1; end
  endtask

  task automatic drive_rack(input bit s, input logic a);
    if (s) rack8 = a; else rack2 = a;
  endtask

  // Reference model: 64-bit products, then wrap or clip to 32-bit at each step.
  function automatic void push_exp(input int dim);
    exp_sat = 1'b0;
    for (int i = 0; i < dim; i++) begin
      for (int j = 0; j < dim; j++) begin
        longint acc = 0;
        for (int k = 0; k < dim; k++) begin
          longint p = longint'(ma[i*dim+k]) * longint'(mb[k*dim+j]);
`ifdef COPROC_MATMUL_SAT_EN
          if (p > 64'sd2147483647)       begin p = 64'sd2147483647;  exp_sat = 1'b1; end
          else if (p < -64'sd2147483648) begin p = -64'sd2147483648; exp_sat = 1'b1; end
          acc = acc + p;
          if (acc > 64'sd2147483647)       begin acc = 64'sd2147483647;  exp_sat = 1'b1; end
          else if (acc < -64'sd2147483648) begin acc = -64'sd2147483648; exp_sat = 1'b1; end
`else
          acc = longint'(int'(acc + longint'(int'(p))));
`endif
        end
        exp_q.push_back(32'(acc));
      end
    end
  endfunction

  task automatic do_load(input bit s, input int dim, input bit hold);
    int waits = 0;
    for (int n = 0; n < dim * dim; n++) begin
      drive_req(s, 1'b1, ma[n], mb[n]);
      #1;
      while (!g_ack(s) && waits < 50) begin
        @(posedge clk); #2;
        waits++;
      end
      @(posedge clk); #1;
    end
    if (!hold) drive_req(s, 1'b0, '0, '0);
    chk("load_wait", waits, 0);
  endtask

  task automatic wait_resp(input bit s, input int dim, input bit hold);
    int lat = 1;
    #1;
    while (!g_rreq(s) && lat < 400) begin
      if (hold) chk("stall_ack", g_ack(s), 1'b0);
      chk("busy_compute", g_busy(s), 1'b1);
      @(posedge clk); #2;
      lat++;
    end
    drive_req(s, 1'b0, '0, '0);
    chk("first_resp_latency", lat, dim * dim + 1);
  endtask

  task automatic do_drain(input bit s, input int dim, input bit bp);
    int cyc = 0;
    while (exp_q.size() > 0 && cyc < 500) begin
      logic a;
      a = bp ? (cyc % 3 == 0) : 1'b1;
      drive_rack(s, a);
      #1;
      chk("drain_req", g_rreq(s), 1'b1);
      chk("drain_data", g_wd(s), exp_q[0]);
      if (a && g_rreq(s)) void'(exp_q.pop_front());
      @(posedge clk); #2;
      cyc++;
    end
    drive_rack(s, 1'b0);
    chk("drain_left", exp_q.size(), 0);
    chk("req_after_drain", g_rreq(s), 1'b0);
    chk("busy_after_drain", g_busy(s), 1'b0);
    if (!bp) chk("drain_cycles", cyc, dim * dim);
  endtask

  initial begin
    rst = 1'b1;
    drive_req(0, 1'b1, 32'h1, 32'h2);
    drive_req(1, 1'b0, '0, '0);
    rack2 = 1'b0; rack8 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_ack2", ack2, 1'b0);
    chk("rst_rreq2", rreq2, 1'b0);
    chk("rst_wd2", wd2, '0);
    chk("rst_busy2", busy2, 1'b0);
    chk("rst_rreq8", rreq8, 1'b0);
    chk("rst_busy8", busy8, 1'b0);
    drive_req(0, 1'b0, '0, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy2", busy2, 1'b0);

    // Identity
    ma[0:3] = '{1, 0, 0, 1};
    mb[0:3] = '{1, 2, 3, 4};
    push_exp(2);
    do_load(0, 2, 0);
    wait_resp(0, 2, 0);
    do_drain(0, 2, 0);

    // Signed product with backpressure
    ma[0:3] = '{1, -2, 3, 4};
    mb[0:3] = '{5, 6, -7, 8};
    push_exp(2);
    do_load(0, 2, 0);
    wait_resp(0, 2, 0);
    do_drain(0, 2, 1);

    // Overflow
    ma[0:3] = '{32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000};
    mb[0:3] = '{32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000};
    push_exp(2);
    do_load(0, 2, 0);
    wait_resp(0, 2, 0);
`ifdef COPROC_MATMUL_SAT_EN
    chk("sat_o", sat2, exp_sat);
`endif
    do_drain(0, 2, 0);

    // Stall during compute, reset in the 3rd drain cycle, then a fresh load
    ma[0:3] = '{2, 1, 0, 3};
    mb[0:3] = '{4, -1, 6, 5};
    do_load(0, 2, 1);
    wait_resp(0, 2, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrst_rreq", rreq2, 1'b0);
    chk("midrst_busy", busy2, 1'b0);
    chk("midrst_wd", wd2, '0);
    ma[0:3] = '{-1, 2, 3, -4};
    mb[0:3] = '{7, -5, 2, 9};
    push_exp(2);
    do_load(0, 2, 0);
    wait_resp(0, 2, 0);
    do_drain(0, 2, 1);

    // DIM=8: all-ones A, B rows filled with their row index; then back-to-back A=2I
    for (int n = 0; n < 64; n++) begin
      ma[n] = 1;
      mb[n] = n / 8;
    end
    push_exp(8);
    do_load(1, 8, 0);
    wait_resp(1, 8, 0);
    chk("c8_first_is_28", exp_q[0], 32'd28);
    do_drain(1, 8, 0);
    for (int n = 0; n < 64; n++) begin
      ma[n] = (n / 8 == n % 8) ? 2 : 0;
      mb[n] = n - 20;
    end
    push_exp(8);
    do_load(1, 8, 0);
    wait_resp(1, 8, 0);
    do_drain(1, 8, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/coproc_matmul_param.md
Name: coproc_matmul_param

Overview:
- Parametrised successor to the fixed 8x8 custom0 matrix-multiply coprocessor: DIM x DIM signed integer product C = A*B.
- Attaches to the core's custom0 genfifo request/response streams.
- Operand beats are loaded, C is computed by a DIM-lane MAC array, then C is drained on the response stream with full backpressure support.
- Compute and result readback are explicit phases, not piggybacked on the next load.

Parameters:
- DIM, 8: matrix dimension; legal range 2..16.
- DATA_W, 32: operand width, signed two's complement.
- RES_W, 32: accumulator and result width, signed; RES_W >= DATA_W.

Ports:
- clk_i  in  1  clock, the only clock.
- rst_i  in  1  synchronous, active-high reset.
- stream_req_bus_genfifo_req_i  in  1  request beat valid.
- stream_req_bus_genfifo_src0_data_bi  in  DATA_W  A element.
- stream_req_bus_genfifo_src1_data_bi  in  DATA_W  B element.
- stream_req_bus_genfifo_ack_o  out  1  request beat accepted.
- stream_resp_bus_genfifo_req_o  out  1  result beat valid.
- stream_resp_bus_genfifo_wdata_bo  out  RES_W  C element.
- stream_resp_bus_genfifo_ack_i  in  1  result beat consumed.
- busy_o  out  1  high in COMPUTE or DRAIN.

Behaviour:
- Reset:
  - Any cycle with rst_i=1, including mid-LOAD, COMPUTE or DRAIN: next state LOAD, all counters 0.
  - Outputs: ack_o=0, resp req_o=0, wdata_bo=0, busy_o=0.
  - A/B/C storage contents are don't-care after reset.
- Transfers:
  - Request transfer = req_i & ack_o. ack_o is combinational: req_i & (state==LOAD).
  - Response transfer = req_o & ack_i.
- State LOAD:
  - Beat n (0..DIM*DIM-1) writes A[n/DIM][n%DIM]=src0 and B[n/DIM][n%DIM]=src1, row-major.
  - The beat with n=DIM*DIM-1 moves the FSM to COMPUTE next cycle. Counter n resets to 0.
  - No response beats are issued in LOAD.
- State COMPUTE:
  - Row counter i and inner counter k each run 0..DIM-1, with k innermost.
  - Each cycle, for all j in parallel: acc[j] = (k==0 ? 0 : acc[j]) + A[i][k]*B[k][j].
  - Products are full 2*DATA_W signed, truncated to RES_W before the add.
  - When k==DIM-1, the updated acc row is written to C[i][*].
  - After exactly DIM*DIM cycles (i=k=DIM-1), go to DRAIN.
  - ack_o=0 throughout, so the request stream stalls.
- State DRAIN:
  - resp req_o is asserted from the first DRAIN cycle. wdata_bo = C[m/DIM][m%DIM], with m starting at 0.
  - req_o and wdata_bo hold stable until ack_i. Each transfer increments m.
  - The transfer of m=DIM*DIM-1 deasserts req_o next cycle and returns to LOAD.
  - ack_i while req_o=0 is ignored.
- Latency:
  - First resp req_o rises DIM*DIM+1 cycles after the cycle of the last load transfer (5 cycles for DIM=2).
  - With ack_i tied high, the drain takes DIM*DIM cycles.
- Arithmetic (default build): RES_W two's-complement addition, wrap-around on overflow, no flags.
- Boundaries:
  - Back-to-back operations are allowed: LOAD accepts a beat in the cycle immediately after the final drain transfer.
  - req_i held high during COMPUTE/DRAIN is not consumed and its data is not sampled.
  - A partial load (fewer than DIM*DIM beats) waits indefinitely; only rst_i aborts it.

Optional Feature:
- Macro: COPROC_MATMUL_SAT_EN.
- Defined:
  - Every truncated product and every accumulation add saturates to [-2^(RES_W-1), 2^(RES_W-1)-1].
  - A sticky output sat_o (1 bit) is added; it goes high on any clipping during COMPUTE.
  - sat_o clears on reset and at entry to COMPUTE, and holds through DRAIN.
- Undefined: wrap-around arithmetic as above; sat_o port absent.

Test Plan:
- Identity (DIM=2): A=I, B={1,2,3,4}, ack_i=1 -> resp beats 1,2,3,4. First req_o 5 cycles after last load ack. busy_o falls with the last beat.
- Signed product (DIM=2): A={1,-2,3,4}, B={5,6,-7,8} -> C={19,-10,-13,50}.
- Backpressure: drain with ack_i toggling 1,0,0,1,… -> wdata_bo constant while ack_i=0. Exactly 4 beats, no duplicates or skips.
- Overflow (DIM=2, RES_W=32): A=B all 0x40000000 -> wrap build: all C=0. SAT build: all C=0x7FFFFFFF, sat_o=1.
- Stall/mid-reset: req_i held high through COMPUTE -> ack_o=0 throughout. rst_i pulsed in the 3rd DRAIN cycle -> req_o=0 next cycle, FSM in LOAD. A fresh load then yields a correct C.
- Default DIM=8: A=all 1s, B=row r filled with r -> every C[i][j]=28. Back-to-back second operation with A=2I -> C=2*B.
